sdram_req_queue: RTL and testbench
==================================

Name: sdram_req_queue

Overview:
- Request buffer between the FSMC peripheral register decode and the SDRAM controller.
- Accepts read and write requests from the FSMC side into a small in-order FIFO.
- Issues them one at a time to the controller using its adv/ack handshake, waiting for completion before the next.
- Returns read data with a one-cycle valid pulse, so the STM32 can post writes back-to-back instead of polling after each one.

Parameters:
AW, 27, SDRAM word-address width
DW, 16, data width
QLOG2, 2, log2 of FIFO depth (depth = 4)

Ports:
clk  in  1  main PLL clock
nrst  in  1  asynchronous active-low reset
req_valid  in  1  request offered this cycle
req_ready  out  1  FIFO can accept; equals !full
req_rwn  in  1  1 = read, 0 = write
req_addr  in  AW  word address
req_wdata  in  DW  write data (ignored for reads)
rd_valid  out  1  one-cycle pulse, rd_data valid
rd_data  out  DW  last read result, held until the next read
busy  out  1  FIFO non-empty or operation in flight
level  out  QLOG2+1  FIFO occupancy
sd_init_done  in  1  controller init complete
sd_busy  in  1  controller busy
sd_adv  out  1  address valid / start request to controller
sd_addr  out  AW  request address
sd_rwn  out  1  request direction
sd_wdata  out  DW  write data
sd_ack  in  1  controller accepted request
sd_write_done  in  1  write completed
sd_data_valid  in  1  read data valid
sd_rdata  in  DW  read data from controller

Behaviour:
- Reset: all outputs 0, FIFO pointers 0, level 0, FSM in IDLE. req_ready goes to 1 after reset (combinational from full).
- Reset mid-operation: nrst low clears immediately. The FIFO contents and any in-flight request are discarded; sd_adv drops asynchronously.
- Push: on req_valid & req_ready at a clk edge, {rwn, addr, wdata} are written at the write pointer and level increments.
- Push while full: req_valid with req_ready=0 is ignored, with no state change.
- Push and pop in the same cycle: allowed when not full. Level is unchanged and both pointers advance.
- Pointers are QLOG2 bits and wrap modulo depth. full = (level == 2^QLOG2); empty = (level == 0).
- FSM states: IDLE, ISSUE, WAIT_DONE.
- IDLE: when !empty & sd_init_done & !sd_busy:
  - load the head entry into sd_addr/sd_rwn/sd_wdata;
  - set sd_adv=1;
  - pop the FIFO;
  - go to ISSUE.
  Earliest sd_adv is the edge after the push edge (1-cycle latency).
- ISSUE: hold sd_adv and sd_* stable until sd_ack is sampled high; then clear sd_adv at that edge.
  - If the completion for the current op (sd_write_done for a write, sd_data_valid for a read) is also high on that edge, complete immediately and go to IDLE.
  - Otherwise go to WAIT_DONE.
- WAIT_DONE, write: on sd_write_done go to IDLE.
- WAIT_DONE, read: on sd_data_valid, capture sd_rdata into rd_data, pulse rd_valid for exactly one cycle, and go to IDLE.
- Completion strobes for the other direction, or any strobe in IDLE, are ignored.
- Ordering: strictly FIFO. A read queued after a write to the same address returns the written value. At most one request is outstanding at the controller.
- sd_addr/sd_rwn/sd_wdata hold their last issued values when idle.
- busy = !empty | (state != IDLE).
- No timeout: the FSM waits indefinitely for ack or completion.

Test Plan:
1. Reset/init gating: reset, hold sd_init_done=0, push write A=0x0000123 D=0xBEEF -> level=1, busy=1, sd_adv stays 0. Raise sd_init_done -> sd_adv=1 next edge with sd_addr=0x123, sd_rwn=0, sd_wdata=0xBEEF.
2. Write then read, same address: push write 0x10/0xA5A5, then read 0x10. Controller model acks after 2 cycles, write_done 3 cycles later, returns 0xA5A5 -> the two sd_adv assertions are in order, rd_valid pulses once, rd_data=0xA5A5, busy=0 after.
3. Full/backpressure: stall the controller (sd_busy=1) and push 5 requests -> req_ready=0 after the 4th, the 5th is dropped, level=4. Release -> exactly 4 requests issued, addresses in push order.
4. Simultaneous push/pop at full-1: level=3 and a pop in the same cycle as a push -> level stays 3; pointer wrap verified by 10 sequential requests with unique data all returned in order.
5. Same-edge ack and completion: sd_ack and sd_data_valid asserted together with sd_rdata=0x5A5A -> rd_valid pulse, no WAIT_DONE cycle, next request issued one edge later.
6. Reset mid-op: assert nrst low while in WAIT_DONE with 2 entries queued -> sd_adv=0, level=0, busy=0 immediately. A later sd_data_valid produces no rd_valid.

Source files
------------

// File: rtl/sdram_req_queue.sv
// Request buffer between the FSMC register decode and the SDRAM controller.
// Queues reads/writes in order, issues them one at a time and pulses rd_valid with read data.
module sdram_req_queue #(
    parameter int AW    = 27,
    parameter int DW    = 16,
    parameter int QLOG2 = 2
) (
    input  logic           clk,
    input  logic           nrst,
    // FSMC side: a request transfers on a clk edge where req_valid & req_ready are
    // both high; req_valid with req_ready low is ignored and changes nothing.
    input  logic           req_valid,
    output logic           req_ready,
    input  logic           req_rwn,
    input  logic [AW-1:0]  req_addr,
    input  logic [DW-1:0]  req_wdata,
    output logic           rd_valid,
    output logic [DW-1:0]  rd_data,
    output logic           busy,
    output logic [QLOG2:0] level,
    output logic [1:0]     dbg_state,
    input  logic           sd_init_done,
    input  logic           sd_busy,
    output logic           sd_adv,
    output logic [AW-1:0]  sd_addr,
    output logic           sd_rwn,
    output logic [DW-1:0]  sd_wdata,
    input  logic           sd_ack,
    input  logic           sd_write_done,
    input  logic           sd_data_valid,
    input  logic [DW-1:0]  sd_rdata
);

    localparam int DEPTH = 1 << QLOG2;
    localparam logic [QLOG2:0]   LVL_ONE  = 1;
    localparam logic [QLOG2:0]   LVL_FULL = {1'b1, {QLOG2{1'b0}}};
    localparam logic [QLOG2-1:0] PTR_ONE  = 1;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [QLOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [QLOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [QLOG2:0]   level_q, level_d;

    logic             fifo_rwn_q   [DEPTH];
    logic             fifo_rwn_d   [DEPTH];
    logic [AW-1:0]    fifo_addr_q  [DEPTH];
    logic [AW-1:0]    fifo_addr_d  [DEPTH];
    logic [DW-1:0]    fifo_wdata_q [DEPTH];
    logic [DW-1:0]    fifo_wdata_d [DEPTH];

    logic             sd_adv_q, sd_adv_d;
    logic [AW-1:0]    sd_addr_q, sd_addr_d;
    logic             sd_rwn_q, sd_rwn_d;
    logic [DW-1:0]    sd_wdata_q, sd_wdata_d;
    logic             rd_valid_q, rd_valid_d;
    logic [DW-1:0]    rd_data_q, rd_data_d;

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic done_now;

    assign full  = (level_q == LVL_FULL);
    assign empty = (level_q == '0);
    assign push  = req_valid & ~full;

    // Completion only counts for the direction of the op currently issued.
    assign done_now = sd_rwn_q ? sd_data_valid : sd_write_done;

    // Controller side: sd_adv and sd_addr/sd_rwn/sd_wdata stay stable from issue
    // until sd_ack is sampled high; only one request is outstanding at a time.
    always_comb begin
        state_d    = state_q;
        sd_adv_d   = sd_adv_q;
        sd_addr_d  = sd_addr_q;
        sd_rwn_d   = sd_rwn_q;
        sd_wdata_d = sd_wdata_q;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        pop        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!empty && sd_init_done && !sd_busy) begin
                    pop        = 1'b1;
                    sd_adv_d   = 1'b1;
                    sd_addr_d  = fifo_addr_q[rd_ptr_q];
                    sd_rwn_d   = fifo_rwn_q[rd_ptr_q];
                    sd_wdata_d = fifo_wdata_q[rd_ptr_q];
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (sd_ack) begin
                    sd_adv_d = 1'b0;
                    if (done_now) begin
                        rd_valid_d = sd_rwn_q;
                        if (sd_rwn_q) begin
                            rd_data_d = sd_rdata;
                        end
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_WAIT_DONE;
                    end
                end
            end
            ST_WAIT_DONE: begin
                if (done_now) begin
                    rd_valid_d = sd_rwn_q;
                    if (sd_rwn_q) begin
                        rd_data_d = sd_rdata;
                    end
                    state_d = ST_IDLE;
                end
            end
            default: begin
                sd_adv_d = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        fifo_rwn_d   = fifo_rwn_q;
        fifo_addr_d  = fifo_addr_q;
        fifo_wdata_d = fifo_wdata_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        level_d      = level_q;

        if (push) begin
            fifo_rwn_d[wr_ptr_q]   = req_rwn;
            fifo_addr_d[wr_ptr_q]  = req_addr;
            fifo_wdata_d[wr_ptr_q] = req_wdata;
            wr_ptr_d               = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        // Simultaneous push and pop leaves the occupancy unchanged.
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            fifo_rwn_q   <= '{default: 1'b0};
            fifo_addr_q  <= '{default: '0};
            fifo_wdata_q <= '{default: '0};
            sd_adv_q     <= 1'b0;
            sd_addr_q    <= '0;
            sd_rwn_q     <= 1'b0;
            sd_wdata_q   <= '0;
            rd_valid_q   <= 1'b0;
            rd_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            fifo_rwn_q   <= fifo_rwn_d;
            fifo_addr_q  <= fifo_addr_d;
            fifo_wdata_q <= fifo_wdata_d;
            sd_adv_q     <= sd_adv_d;
            sd_addr_q    <= sd_addr_d;
            sd_rwn_q     <= sd_rwn_d;
            sd_wdata_q   <= sd_wdata_d;
            rd_valid_q   <= rd_valid_d;
            rd_data_q    <= rd_data_d;
        end
    end

    assign req_ready = ~full;
    assign busy      = ~empty | (state_q != ST_IDLE);
    assign level     = level_q;
    assign dbg_state = state_q;
    assign sd_adv    = sd_adv_q;
    assign sd_addr   = sd_addr_q;
    assign sd_rwn    = sd_rwn_q;
    assign sd_wdata  = sd_wdata_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;

endmodule

// File: tb/tb_sdram_req_queue.sv
// Bench for sdram_req_queue: a simple SDRAM controller responder plus an in-order
// reference model (request queue and memory image) that predicts issue order and read data.
module tb_sdram_req_queue;

    localparam int AW    = 27;
    localparam int DW    = 16;
    localparam int QLOG2 = 2;
    localparam int RW    = 1 + AW + DW;

    logic           clk;
    logic           nrst;
    logic           req_valid;
    logic           req_ready;
    logic           req_rwn;
    logic [AW-1:0]  req_addr;
    logic [DW-1:0]  req_wdata;
    logic           rd_valid;
    logic [DW-1:0]  rd_data;
    logic           busy;
    logic [QLOG2:0] level;
    logic [1:0]     dbg_state;
    logic           sd_init_done;
    logic           sd_busy;
    logic           sd_adv;
    logic [AW-1:0]  sd_addr;
    logic           sd_rwn;
    logic [DW-1:0]  sd_wdata;
    logic           sd_ack;
    logic           sd_write_done;
    logic           sd_data_valid;
    logic [DW-1:0]  sd_rdata;

    logic [RW-1:0] exp_q[$];
    logic [RW-1:0] iss_q[$];
    logic [DW-1:0] exp_rd_q[$];
    logic [DW-1:0] rd_got_q[$];
    logic [DW-1:0] ref_mem [logic [AW-1:0]];
    logic [DW-1:0] ctl_mem [logic [AW-1:0]];

    int n_cmp;
    int n_bad;

    sdram_req_queue #(.AW(AW), .DW(DW), .QLOG2(QLOG2)) dut (
        .clk           (clk),
        .nrst          (nrst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_rwn       (req_rwn),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .rd_valid      (rd_valid),
        .rd_data       (rd_data),
        .busy          (busy),
        .level         (level),
        .dbg_state     (dbg_state),
        .sd_init_done  (sd_init_done),
        .sd_busy       (sd_busy),
        .sd_adv        (sd_adv),
        .sd_addr       (sd_addr),
        .sd_rwn        (sd_rwn),
        .sd_wdata      (sd_wdata),
        .sd_ack        (sd_ack),
        .sd_write_done (sd_write_done),
        .sd_data_valid (sd_data_valid),
        .sd_rdata      (sd_rdata)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Read-data monitor: every cycle rd_valid is high yields one returned word.
    initial begin : rd_monitor
        forever begin
            @(negedge clk);
            if (rd_valid === 1'b1) rd_got_q.push_back(rd_data);
        end
    end

    // ---------------- model helpers ----------------
    function automatic logic [DW-1:0] dflt_data(input logic [AW-1:0] a);
        return a[DW-1:0] ^ 16'h3C3C;
    endfunction

    function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt_data(a);
    endfunction

    function automatic logic [DW-1:0] ctl_read(input logic [AW-1:0] a);
        return ctl_mem.exists(a) ? ctl_mem[a] : dflt_data(a);
    endfunction

    task automatic clear_sb();
        exp_q.delete();
        iss_q.delete();
        exp_rd_q.delete();
        rd_got_q.delete();
        ref_mem.delete();
        ctl_mem.delete();
    endtask

    // ---------------- driver tasks ----------------
    task automatic push_req(input logic rwn, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            output bit accepted);
        req_valid = 1'b1;
        req_rwn   = rwn;
        req_addr  = a;
        req_wdata = d;
        accepted  = (req_ready === 1'b1);
        if (accepted) begin
            exp_q.push_back({rwn, a, d});
            if (rwn) exp_rd_q.push_back(ref_read(a));
            else     ref_mem[a] = d;
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic push_wait(input logic rwn, input logic [AW-1:0] a, input logic [DW-1:0] d,
                             output bit ok);
        bit acc;
        int tries;
        acc = 1'b0;
        tries = 0;
        while (!acc && tries < 300) begin
            push_req(rwn, a, d, acc);
            tries++;
        end
        ok = acc;
    endtask

    task automatic clear_strobes();
        sd_write_done = 1'b0;
        sd_data_valid = 1'b0;
        sd_rdata      = DW'($urandom);
    endtask

    task automatic drive_done(input logic rwn, input logic [AW-1:0] a);
        if (rwn) begin
            sd_data_valid = 1'b1;
            sd_rdata      = ctl_read(a);
        end else begin
            sd_write_done = 1'b1;
        end
    endtask

    // Controller responder for one request: wait for sd_adv, ack, then complete.
    task automatic ctl_serve(input int ack_dly, input int done_dly, input bit same_edge,
                             input bit noise, output bit ok);
        logic          rwn;
        logic [AW-1:0] a;
        int            n;
        ok = 1'b0;
        n  = 0;
        while (sd_adv !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (sd_adv !== 1'b1) return;
        rwn = sd_rwn;
        a   = sd_addr;
        iss_q.push_back({sd_rwn, sd_addr, sd_wdata});
        if (!rwn) ctl_mem[a] = sd_wdata;
        repeat (ack_dly) @(negedge clk);
        sd_ack = 1'b1;
        if (same_edge) drive_done(rwn, a);
        @(negedge clk);
        sd_ack = 1'b0;
        clear_strobes();
        if (!same_edge) begin
            for (int i = 0; i < done_dly; i++) begin
                if (noise) begin
                    if (rwn) sd_write_done = 1'b1;
                    else     sd_data_valid = 1'b1;
                end
                @(negedge clk);
                clear_strobes();
            end
            drive_done(rwn, a);
            @(negedge clk);
            clear_strobes();
        end
        ok = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        nrst = 1'b0;
        req_valid = 1'b0; req_rwn = 1'b0; req_addr = '0; req_wdata = '0;
        sd_init_done = 1'b0; sd_busy = 1'b0; sd_ack = 1'b0;
        sd_write_done = 1'b0; sd_data_valid = 1'b0; sd_rdata = '0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({sd_adv, rd_valid, busy} !== 3'b000) begin
            n_bad++; $display("FAIL reset_ctrl: got adv/rdv/busy=%b exp 000", {sd_adv, rd_valid, busy});
        end
        n_cmp++;
        if (level !== '0) begin n_bad++; $display("FAIL reset_level: got %0d exp 0", level); end
        n_cmp++;
        if (sd_addr !== '0 || sd_wdata !== '0 || sd_rwn !== 1'b0 || rd_data !== '0) begin
            n_bad++; $display("FAIL reset_data: got addr=%h wdata=%h rwn=%b rd=%h exp all 0",
                              sd_addr, sd_wdata, sd_rwn, rd_data);
        end
        nrst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b exp 1", req_ready); end
    endtask

    task automatic test_init_gating();
        bit acc;
        bit ok;
        clear_sb();
        push_req(1'b0, 27'h0000123, 16'hBEEF, acc);
        n_cmp++;
        if (acc !== 1'b1) begin n_bad++; $display("FAIL init_accept: got %b exp 1", acc); end
        n_cmp++;
        if (level !== 3'd1 || busy !== 1'b1) begin
            n_bad++; $display("FAIL init_queued: got level=%0d busy=%b exp level=1 busy=1", level, busy);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (sd_adv !== 1'b0) begin n_bad++; $display("FAIL init_gate_adv: got %b exp 0", sd_adv); end
            @(negedge clk);
        end
        sd_init_done = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (sd_adv !== 1'b1 || sd_addr !== 27'h123 || sd_rwn !== 1'b0 || sd_wdata !== 16'hBEEF) begin
            n_bad++; $display("FAIL init_issue: got adv=%b addr=%h rwn=%b wdata=%h exp 1/123/0/beef",
                              sd_adv, sd_addr, sd_rwn, sd_wdata);
        end
        n_cmp++;
        if (level !== 3'd0) begin n_bad++; $display("FAIL init_pop_level: got %0d exp 0", level); end
        ctl_serve(1, 1, 1'b0, 1'b0, ok);
        repeat (2) @(negedge clk);
        n_cmp++;
        if (!ok || busy !== 1'b0) begin
            n_bad++; $display("FAIL init_complete: got served=%b busy=%b exp 1/0", ok, busy);
        end
    endtask

    task automatic test_write_read();
        bit acc;
        bit ok1;
        bit ok2;
        clear_sb();
        push_req(1'b0, 27'h10, 16'hA5A5, acc);
        push_req(1'b1, 27'h10, 16'h0F0F, acc);
        ctl_serve(2, 3, 1'b0, 1'b0, ok1);
        ctl_serve(2, 3, 1'b0, 1'b0, ok2);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (!(ok1 && ok2) || iss_q.size() != 2) begin
            n_bad++; $display("FAIL wr_rd_issue_count: got %0d exp 2", iss_q.size());
        end
        for (int i = 0; i < iss_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (iss_q[i] !== exp_q[i]) begin
                n_bad++; $display("FAIL wr_rd_issue[%0d]: got %h exp %h", i, iss_q[i], exp_q[i]);
            end
        end
        n_cmp++;
        if (rd_got_q.size() != 1) begin
            n_bad++; $display("FAIL wr_rd_pulses: got %0d exp 1", rd_got_q.size());
        end else begin
            n_cmp++;
            if (rd_got_q[0] !== 16'hA5A5) begin
                n_bad++; $display("FAIL wr_rd_data: got %h exp a5a5", rd_got_q[0]);
            end
        end
        n_cmp++;
        if (rd_data !== 16'hA5A5 || busy !== 1'b0 || rd_valid !== 1'b0) begin
            n_bad++; $display("FAIL wr_rd_after: got rd_data=%h busy=%b rd_valid=%b exp a5a5/0/0",
                              rd_data, busy, rd_valid);
        end
    endtask

    task automatic test_full_backpressure();
        bit acc;
        bit ok;
        int extra;
        clear_sb();
        sd_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push_req(1'b0, AW'(32'h200 + 32'(i) * 3), DW'($urandom), acc);
            n_cmp++;
            if (acc !== bit'(i < 4)) begin
                n_bad++; $display("FAIL full_accept[%0d]: got %b exp %b", i, acc, bit'(i < 4));
            end
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (level !== 3'd4 || req_ready !== 1'b0 || sd_adv !== 1'b0) begin
            n_bad++; $display("FAIL full_state: got level=%0d ready=%b adv=%b exp 4/0/0",
                              level, req_ready, sd_adv);
        end
        sd_busy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ctl_serve($urandom_range(0, 2), $urandom_range(0, 2), 1'b0, 1'b0, ok);
            n_cmp++;
            if (!ok) begin n_bad++; $display("FAIL full_serve[%0d]: got timeout exp issue", i); end
        end
        extra = 0;
        repeat (8) begin
            @(negedge clk);
            if (sd_adv === 1'b1) extra++;
        end
        n_cmp++;
        if (extra != 0 || iss_q.size() != 4) begin
            n_bad++; $display("FAIL full_issue_count: got %0d extra_adv=%0d exp 4/0", iss_q.size(), extra);
        end
        for (int i = 0; i < iss_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (iss_q[i] !== exp_q[i]) begin
                n_bad++; $display("FAIL full_order[%0d]: got %h exp %h", i, iss_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_push_pop_full1();
        bit acc;
        bit ok;
        int timeouts;
        clear_sb();
        sd_busy = 1'b1;
        for (int i = 0; i < 3; i++) push_req(1'b0, AW'(32'h300 + 32'(i)), DW'(32'h7700 + 32'(i)), acc);
        n_cmp++;
        if (level !== 3'd3 || sd_adv !== 1'b0) begin
            n_bad++; $display("FAIL pp_pre: got level=%0d adv=%b exp 3/0", level, sd_adv);
        end
        sd_busy = 1'b0;
        push_req(1'b0, 27'h303, 16'h7703, acc);
        n_cmp++;
        if (acc !== 1'b1 || level !== 3'd3 || sd_adv !== 1'b1 || sd_addr !== 27'h300) begin
            n_bad++; $display("FAIL pp_same_cycle: got acc=%b level=%0d adv=%b addr=%h exp 1/3/1/300",
                              acc, level, sd_adv, sd_addr);
        end
        for (int i = 0; i < 4; i++) ctl_serve(1, 1, 1'b0, 1'b0, ok);
        repeat (2) @(negedge clk);
        n_cmp++;
        if (iss_q.size() != 4) begin n_bad++; $display("FAIL pp_count: got %0d exp 4", iss_q.size()); end
        for (int i = 0; i < iss_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (iss_q[i] !== exp_q[i]) begin
                n_bad++; $display("FAIL pp_order[%0d]: got %h exp %h", i, iss_q[i], exp_q[i]);
            end
        end

        // Ten requests walk the pointers past the wrap point twice.
        clear_sb();
        timeouts = 0;
        fork
            begin
                bit pok;
                for (int i = 0; i < 10; i++) begin
                    push_wait(logic'(i >= 5), AW'(32'h400 + 32'(i % 5)), DW'(32'h1000 + 32'(i) * 32'h111), pok);
                    if (!pok) timeouts++;
                end
            end
            begin
                bit sok;
                for (int i = 0; i < 10; i++) begin
                    ctl_serve($urandom_range(0, 3), $urandom_range(0, 3), 1'b0, 1'b0, sok);
                    if (!sok) begin
                        timeouts++;
                        break;
                    end
                end
            end
        join
        repeat (4) @(negedge clk);
        n_cmp++;
        if (timeouts != 0 || iss_q.size() != 10 || rd_got_q.size() != 5) begin
            n_bad++; $display("FAIL wrap_counts: got timeouts=%0d issued=%0d reads=%0d exp 0/10/5",
                              timeouts, iss_q.size(), rd_got_q.size());
        end
        for (int i = 0; i < iss_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (iss_q[i] !== exp_q[i]) begin
                n_bad++; $display("FAIL wrap_order[%0d]: got %h exp %h", i, iss_q[i], exp_q[i]);
            end
        end
        for (int i = 0; i < rd_got_q.size() && i < exp_rd_q.size(); i++) begin
            n_cmp++;
            if (rd_got_q[i] !== exp_rd_q[i]) begin
                n_bad++; $display("FAIL wrap_rdata[%0d]: got %h exp %h", i, rd_got_q[i], exp_rd_q[i]);
            end
        end
    endtask

    task automatic test_same_edge();
        bit acc;
        bit ok;
        int n;
        clear_sb();
        ctl_mem[27'h20] = 16'h5A5A;
        ref_mem[27'h20] = 16'h5A5A;
        push_req(1'b1, 27'h20, 16'h0000, acc);
        push_req(1'b0, 27'h30, 16'h1111, acc);
        n = 0;
        while (sd_adv !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (sd_adv !== 1'b1 || sd_addr !== 27'h20 || sd_rwn !== 1'b1) begin
            n_bad++; $display("FAIL se_issue: got adv=%b addr=%h rwn=%b exp 1/20/1", sd_adv, sd_addr, sd_rwn);
        end
        sd_ack        = 1'b1;
        sd_data_valid = 1'b1;
        sd_rdata      = 16'h5A5A;
        @(negedge clk);
        sd_ack = 1'b0;
        clear_strobes();
        n_cmp++;
        if (rd_valid !== 1'b1 || rd_data !== 16'h5A5A || sd_adv !== 1'b0) begin
            n_bad++; $display("FAIL se_complete: got rdv=%b rd=%h adv=%b exp 1/5a5a/0", rd_valid, rd_data, sd_adv);
        end
        @(negedge clk);
        n_cmp++;
        if (rd_valid !== 1'b0 || sd_adv !== 1'b1 || sd_addr !== 27'h30 || sd_rwn !== 1'b0 ||
            sd_wdata !== 16'h1111) begin
            n_bad++; $display("FAIL se_next_issue: got rdv=%b adv=%b addr=%h rwn=%b wd=%h exp 0/1/30/0/1111",
                              rd_valid, sd_adv, sd_addr, sd_rwn, sd_wdata);
        end
        ctl_serve(1, 1, 1'b0, 1'b0, ok);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (!ok || rd_got_q.size() != 1 || busy !== 1'b0) begin
            n_bad++; $display("FAIL se_after: got served=%b pulses=%0d busy=%b exp 1/1/0", ok, rd_got_q.size(), busy);
        end
    endtask

    task automatic test_reset_mid_op();
        bit acc;
        int n;
        int bad_cycles;
        clear_sb();
        ctl_mem[27'h40] = 16'h4444;
        push_req(1'b1, 27'h40, 16'h0000, acc);
        push_req(1'b0, 27'h41, 16'hAAAA, acc);
        push_req(1'b0, 27'h42, 16'hBBBB, acc);
        n = 0;
        while (sd_adv !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        sd_ack = 1'b1;
        @(negedge clk);
        sd_ack = 1'b0;
        n_cmp++;
        if (sd_adv !== 1'b0 || level !== 3'd2 || busy !== 1'b1) begin
            n_bad++; $display("FAIL rmo_wait: got adv=%b level=%0d busy=%b exp 0/2/1", sd_adv, level, busy);
        end
        #2 nrst = 1'b0;
        #1;
        n_cmp++;
        if (sd_adv !== 1'b0 || level !== 3'd0 || busy !== 1'b0 || req_ready !== 1'b1) begin
            n_bad++; $display("FAIL rmo_async_clear: got adv=%b level=%0d busy=%b ready=%b exp 0/0/0/1",
                              sd_adv, level, busy, req_ready);
        end
        @(negedge clk);
        nrst = 1'b1;
        sd_data_valid = 1'b1;
        sd_rdata      = 16'h7777;
        @(negedge clk);
        clear_strobes();
        bad_cycles = 0;
        repeat (6) begin
            if (rd_valid === 1'b1 || sd_adv === 1'b1) bad_cycles++;
            @(negedge clk);
        end
        n_cmp++;
        if (bad_cycles != 0 || rd_got_q.size() != 0 || level !== 3'd0) begin
            n_bad++; $display("FAIL rmo_discard: got bad_cycles=%0d pulses=%0d level=%0d exp 0/0/0",
                              bad_cycles, rd_got_q.size(), level);
        end

        // A reset while sd_adv is still high must drop it without a clock edge.
        push_req(1'b0, 27'h50, 16'h5050, acc);
        n = 0;
        while (sd_adv !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        #2 nrst = 1'b0;
        #1;
        n_cmp++;
        if (sd_adv !== 1'b0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL rmo_issue_reset: got adv=%b busy=%b exp 0/0", sd_adv, busy);
        end
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_random_traffic();
        int timeouts;
        clear_sb();
        timeouts = 0;
        fork
            begin
                bit pok;
                for (int i = 0; i < 40; i++) begin
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    push_wait(logic'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), DW'($urandom), pok);
                    if (!pok) timeouts++;
                end
            end
            begin
                bit sok;
                for (int i = 0; i < 40; i++) begin
                    ctl_serve($urandom_range(0, 3), $urandom_range(0, 3), ($urandom_range(0, 3) == 0),
                              bit'($urandom_range(0, 1)), sok);
                    if (!sok) begin
                        timeouts++;
                        break;
                    end
                end
            end
        join
        repeat (4) @(negedge clk);
        n_cmp++;
        if (timeouts != 0 || iss_q.size() != exp_q.size() || rd_got_q.size() != exp_rd_q.size()) begin
            n_bad++; $display("FAIL rand_counts: got timeouts=%0d issued=%0d/%0d reads=%0d/%0d",
                              timeouts, iss_q.size(), exp_q.size(), rd_got_q.size(), exp_rd_q.size());
        end
        for (int i = 0; i < iss_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (iss_q[i] !== exp_q[i]) begin
                n_bad++; $display("FAIL rand_order[%0d]: got %h exp %h", i, iss_q[i], exp_q[i]);
            end
        end
        for (int i = 0; i < rd_got_q.size() && i < exp_rd_q.size(); i++) begin
            n_cmp++;
            if (rd_got_q[i] !== exp_rd_q[i]) begin
                n_bad++; $display("FAIL rand_rdata[%0d]: got %h exp %h", i, rd_got_q[i], exp_rd_q[i]);
            end
        end
        n_cmp++;
        if (busy !== 1'b0 || level !== 3'd0) begin
            n_bad++; $display("FAIL rand_idle: got busy=%b level=%0d exp 0/0", busy, level);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_init_gating();
        test_write_read();
        test_full_backpressure();
        test_push_pop_full1();
        test_same_edge();
        test_reset_mid_op();
        test_random_traffic();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
